// File: rtl/cdb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdb_pkg : shared types and constants for the common data bus (writeback)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cdb_pkg;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;

  // All-ones tag marks "no instruction" on the bus and in requests.
  localparam logic [CDB_TAG_W-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  rd;
  } cdb_req_t;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic                  rd;
  } cdb_bcast_t;

  localparam cdb_bcast_t BCAST_IDLE = '{valid: 1'b0, tag: TAG_INVALID, data: '0, rd: 1'b0};

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_picker : combinational round-robin pick of the first eligible index    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int idx;

  // Scan rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_valid && eligible[PTR_W'(idx)]) begin
        grant[PTR_W'(idx)] = 1'b1;
        grant_idx          = PTR_W'(idx);
        grant_valid        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cdb_arbiter : round-robin arbiter for the single writeback (CDB) bus       |
// | Optional contention counter enabled by CDB_STALL_CNT_EN. Revision: 1.0     |
// +----------------------------------------------------------------------------+
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int TAG_W   = CDB_TAG_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_rd,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           wb_valid,
  output logic [TAG_W-1:0]               wb_tag,
  output logic [DATA_W-1:0]              wb_data,
  output logic                           wb_rd,
  output logic [31:0]                    stall_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] drop;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               take;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_next;
  cdb_req_t           sel;
  cdb_bcast_t         bcast_q;

  // Invalid-tag requests are swallowed at once and never compete.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign eligible[i] = req_valid[i] && (req_tag[i] != TAG_INVALID);
    assign drop[i]     = req_valid[i] && (req_tag[i] == TAG_INVALID);
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign take      = grant_valid && !flush;
  assign req_ready = drop | (flush ? '0 : grant);

  assign sel.tag  = req_tag[grant_idx];
  assign sel.data = req_data[grant_idx];
  assign sel.rd   = req_rd[grant_idx];

  assign rr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcast_q <= BCAST_IDLE;
      rr_ptr  <= '0;
    end else if (take) begin
      bcast_q <= '{valid: 1'b1, tag: sel.tag, data: sel.data, rd: sel.rd};
      rr_ptr  <= rr_next;
    end else begin
      bcast_q <= BCAST_IDLE;
    end
  end

  assign wb_valid = bcast_q.valid;
  assign wb_tag   = bcast_q.tag;
  assign wb_data  = bcast_q.data;
  assign wb_rd    = bcast_q.rd;

`ifdef CDB_STALL_CNT_EN
  logic        contended;
  logic [31:0] stall_q;

  // Two or more eligible bits set means at least one unit was denied.
  assign contended = |(eligible & (eligible - NUM_REQ'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (!flush && contended && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cdb_arbiter : directed vector bench for cdb_arbiter                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [N-1:0]          req_valid;
  logic [N-1:0][4:0]     req_tag;
  logic [N-1:0][31:0]    req_data;
  logic [N-1:0]          req_rd;
  logic [N-1:0]          req_ready;
  logic                  wb_valid;
  logic [4:0]            wb_tag;
  logic [31:0]           wb_data;
  logic                  wb_rd;
  logic [31:0]           stall_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_stall = 32'd0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .DATA_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_rd    (req_rd),
    .req_ready (req_ready),
    .wb_valid  (wb_valid),
    .wb_tag    (wb_tag),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic [3:0]      valid;
    logic [3:0][4:0] tag;
    logic            flush;
    logic [3:0]      ready;
    logic            wbv;
    logic [4:0]      wbt;
    int              widx;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input logic [4:0] tag, input int idx);
    return {8'hD0, 3'b000, tag, 8'(idx), 8'hA5};
  endfunction

  function automatic vec_t mkv(input logic [3:0] valid, input int t0, input int t1, input int t2,
                               input int t3, input logic fl, input logic [3:0] rdy,
                               input logic wbv, input int wbt, input int widx);
    vec_t v;
    v.valid  = valid;
    v.tag[0] = 5'(t0);
    v.tag[1] = 5'(t1);
    v.tag[2] = 5'(t2);
    v.tag[3] = 5'(t3);
    v.flush  = fl;
    v.ready  = rdy;
    v.wbv    = wbv;
    v.wbt    = 5'(wbt);
    v.widx   = widx;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    flush = v.flush;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = v.valid[i];
      req_tag[i]   = v.tag[i];
      req_data[i]  = mk_data(v.tag[i], i);
      req_rd[i]    = v.tag[i][0];
    end
  endtask

  // Called shortly after a rising edge: drive, check ready mid-cycle, then the broadcast.
  task automatic step(input string nm, input vec_t v);
    int elig;
    drive(v);
    #4;
    check({nm, " ready"}, 32'(req_ready), 32'(v.ready));
    elig = 0;
    for (int i = 0; i < N; i++) begin
      if (v.valid[i] && v.tag[i] != 5'h1F) elig++;
    end
`ifdef CDB_STALL_CNT_EN
    if (!v.flush && elig >= 2) exp_stall = exp_stall + 32'd1;
`endif
    @(posedge clk);
    #1;
    check({nm, " wb_valid"}, 32'(wb_valid), 32'(v.wbv));
    check({nm, " wb_tag"}, 32'(wb_tag), 32'(v.wbt));
    if (v.wbv) begin
      check({nm, " wb_data"}, wb_data, mk_data(v.wbt, v.widx));
      check({nm, " wb_rd"}, 32'(wb_rd), 32'(v.wbt[0]));
    end
    check({nm, " stall_cnt"}, stall_cnt, exp_stall);
  endtask

  initial begin
    // full contention, rr_ptr 0
    vecs[0]  = mkv(4'b1111,  1,  2,  3,  4, 1'b0, 4'b0001, 1'b1,  1, 0);
    vecs[1]  = mkv(4'b1110,  1,  2,  3,  4, 1'b0, 4'b0010, 1'b1,  2, 1);
    vecs[2]  = mkv(4'b1100,  1,  2,  3,  4, 1'b0, 4'b0100, 1'b1,  3, 2);
    vecs[3]  = mkv(4'b1000,  1,  2,  3,  4, 1'b0, 4'b1000, 1'b1,  4, 3);
    // move pointer to 3, then wrap 3 -> 0
    vecs[4]  = mkv(4'b0100,  0,  0,  8,  0, 1'b0, 4'b0100, 1'b1,  8, 2);
    vecs[5]  = mkv(4'b1001,  9,  0,  0,  7, 1'b0, 4'b1000, 1'b1,  7, 3);
    vecs[6]  = mkv(4'b0001,  9,  0,  0,  0, 1'b0, 4'b0001, 1'b1,  9, 0);
    vecs[7]  = mkv(4'b0011,  3,  4,  0,  0, 1'b0, 4'b0010, 1'b1,  4, 1);
    vecs[8]  = mkv(4'b0001,  3,  0,  0,  0, 1'b0, 4'b0001, 1'b1,  3, 0);
    // invalid tag dropped alongside a real grant
    vecs[9]  = mkv(4'b0110,  0, 31,  5,  0, 1'b0, 4'b0110, 1'b1,  5, 2);
    vecs[10] = mkv(4'b1001, 12,  0,  0, 13, 1'b0, 4'b1000, 1'b1, 13, 3);
    vecs[11] = mkv(4'b0001, 12,  0,  0,  0, 1'b0, 4'b0001, 1'b1, 12, 0);
    vecs[12] = mkv(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0000, 1'b0, 31, 0);
    // flush after a grant
    vecs[13] = mkv(4'b0001,  6,  0,  0,  0, 1'b0, 4'b0001, 1'b1,  6, 0);
    vecs[14] = mkv(4'b1011, 20, 14,  0, 31, 1'b1, 4'b1000, 1'b0, 31, 0);
    vecs[15] = mkv(4'b0011, 20, 14,  0,  0, 1'b0, 4'b0010, 1'b1, 14, 1);
    vecs[16] = mkv(4'b0001, 20,  0,  0,  0, 1'b0, 4'b0001, 1'b1, 20, 0);
    // back-to-back single requester
    vecs[17] = mkv(4'b0100,  0,  0, 10,  0, 1'b0, 4'b0100, 1'b1, 10, 2);
    vecs[18] = mkv(4'b0100,  0,  0, 11,  0, 1'b0, 4'b0100, 1'b1, 11, 2);
    vecs[19] = mkv(4'b0100,  0,  0, 12,  0, 1'b0, 4'b0100, 1'b1, 12, 2);

    rst = 1'b1;
    drive(mkv(4'b0000, 0, 0, 0, 0, 1'b0, 4'b0000, 1'b0, 31, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset wb_valid", 32'(wb_valid), 32'd0);
    check("reset wb_tag", 32'(wb_tag), 32'h1F);
    check("reset wb_data", wb_data, 32'd0);
    check("reset wb_rd", 32'(wb_rd), 32'd0);
    check("reset stall_cnt", stall_cnt, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 20; k++) begin
      step($sformatf("vec%0d", k), vecs[k]);
    end

    // async reset while a broadcast is on the bus
    drive(mkv(4'b0001, 1, 0, 0, 0, 1'b0, 4'b0001, 1'b1, 1, 0));
    @(posedge clk);
    #1;
    check("pre-rst wb_valid", 32'(wb_valid), 32'd1);
    check("pre-rst wb_tag", 32'(wb_tag), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid-rst wb_valid", 32'(wb_valid), 32'd0);
    check("mid-rst wb_tag", 32'(wb_tag), 32'h1F);
    check("mid-rst wb_data", wb_data, 32'd0);
    check("mid-rst stall_cnt", stall_cnt, 32'd0);
    exp_stall = 32'd0;
    #1 rst = 1'b0;
    // pointer back at 0: unit 0 must beat unit 1
    step("post-rst", mkv(4'b0011, 2, 3, 0, 0, 1'b0, 4'b0001, 1'b1, 2, 0));
    step("post-rst idle", mkv(4'b0000, 0, 0, 0, 0, 1'b0, 4'b0000, 1'b0, 31, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
